// File: rtl/ysyx_22041071_rd_arb_pkg.sv
// rtl/ysyx_22041071_rd_arb_pkg.sv - shared types and constants for the read-request arbiter
//
// Purpose : FSM state encoding, transfer size codes, AXI response codes,
//           requester ownership codes, default AXI IDs and the alignment
//           check used at request acceptance.
// Ports   : none (package).

package ysyx_22041071_rd_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } rd_state_e;

   // Transfer size codes (log2 of the byte count)
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   // AXI read response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Requester ownership / last-grant encoding
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   // Default AXI IDs per requester
   localparam int unsigned IFU_ID_DEF = 0;
   localparam int unsigned LSU_ID_DEF = 1;

   // An access is misaligned when the address is not a multiple of 2^size.
   // Only the low three address bits matter for sizes up to a doubleword.
   function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
      logic v;
      case (size)
         SZ_B:    v = 1'b0;
         SZ_H:    v = addr_lo[0];
         SZ_W:    v = |addr_lo[1:0];
         default: v = |addr_lo;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/ysyx_22041071_load_align.sv
// rtl/ysyx_22041071_load_align.sv - beat shift, load extension and instruction select
//
// Purpose : Combinational alignment of a returned 64-bit read beat.
//           Loads are shifted down by the byte offset, then sign- or
//           zero-extended from the access size. Fetches pick the 32-bit
//           half selected by address bit 2.
// Ports   : i_beat      - raw beat from the bridge (bytes in place)
//           i_addr_lo   - low three bits of the access address
//           i_size      - access size code (B/H/W/D)
//           i_unsigned  - 1 = zero-extend, 0 = sign-extend
//           o_load      - aligned, extended load data
//           o_inst      - instruction word for fetches

module ysyx_22041071_load_align
   import ysyx_22041071_rd_arb_pkg::*;
(
   input  logic [63:0] i_beat,
   input  logic [2:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [63:0] o_load,
   output logic [31:0] o_inst
);

   logic [63:0] w_sh;
   logic        w_sign;

   assign w_sh = i_beat >> {i_addr_lo, 3'b000};

   always_comb begin
      o_load = w_sh;
      w_sign = 1'b0;
      case (i_size)
         SZ_B: begin
            w_sign = ~i_unsigned & w_sh[7];
            o_load = {{56{w_sign}}, w_sh[7:0]};
         end
         SZ_H: begin
            w_sign = ~i_unsigned & w_sh[15];
            o_load = {{48{w_sign}}, w_sh[15:0]};
         end
         SZ_W: begin
            w_sign = ~i_unsigned & w_sh[31];
            o_load = {{32{w_sign}}, w_sh[31:0]};
         end
         default: begin
            o_load = w_sh;
         end
      endcase
   end

   assign o_inst = i_addr_lo[2] ? i_beat[63:32] : i_beat[31:0];

endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// rtl/ysyx_22041071_axi_rd_arb.sv - IFU/LSU read-request arbiter and response aligner
//
// Purpose : Round-robin arbitration between single-beat IFU fetches and
//           LSU loads, issue of one request at a time to the AXI read
//           bridge, and return of an aligned one-cycle response to the
//           owning requester. Misaligned requests are answered with an
//           error without touching the bus.
// Ports   : clk, reset_n          - clock, synchronous active-low reset
//           ifu_req_*             - fetch request (valid/addr/ready)
//           ifu_resp_*            - fetch response pulse (valid/inst/err)
//           lsu_req_*             - load request (valid/addr/size/unsigned/ready)
//           lsu_resp_*            - load response pulse (valid/data/err)
//           dn_ar_valid/ready     - request handshake to the bridge
//           dn_id/addr/len/size   - request fields, held through the handshake
//           dn_r_valid/data/resp  - returned beat from the bridge

module ysyx_22041071_axi_rd_arb
   import ysyx_22041071_rd_arb_pkg::*;
#(
   parameter int          ADDR_W = 64,
   parameter int          DATA_W = 64,
   parameter int          ID_W   = 4,
   parameter int unsigned IFU_ID = IFU_ID_DEF,
   parameter int unsigned LSU_ID = LSU_ID_DEF
)(
   input  logic              clk,
   input  logic              reset_n,

   input  logic              ifu_req_valid,
   input  logic [ADDR_W-1:0] ifu_req_addr,
   output logic              ifu_req_ready,
   output logic              ifu_resp_valid,
   output logic [31:0]       ifu_resp_inst,
   output logic              ifu_resp_err,

   input  logic              lsu_req_valid,
   input  logic [ADDR_W-1:0] lsu_req_addr,
   input  logic [1:0]        lsu_req_size,
   input  logic              lsu_req_unsigned,
   output logic              lsu_req_ready,
   output logic              lsu_resp_valid,
   output logic [63:0]       lsu_resp_data,
   output logic              lsu_resp_err,

   output logic              dn_ar_valid,
   input  logic              dn_ar_ready,
   output logic [ID_W-1:0]   dn_id,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_len,
   output logic [1:0]        dn_size,
   input  logic              dn_r_valid,
   input  logic [DATA_W-1:0] dn_r_data,
   input  logic [1:0]        dn_r_resp
);

   localparam logic [ID_W-1:0] W_IFU_ID = ID_W'(IFU_ID);
   localparam logic [ID_W-1:0] W_LSU_ID = ID_W'(LSU_ID);

   rd_state_e         r_state;
   rd_state_e         w_state_nxt;

   logic              r_last_grant;
   logic              r_owner;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [63:0]       r_data;
   logic              r_err;

   logic              w_gnt_ifu;
   logic              w_gnt_lsu;
   logic              w_accept;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [1:0]        w_acc_size;
   logic              w_misalign;
   logic              w_bus_err;
   logic [63:0]       w_load;
   logic [31:0]       w_inst;

   // On a tie the requester that did not win last time is served.
   assign w_gnt_lsu  = lsu_req_valid & (~ifu_req_valid | (r_last_grant == OWN_IFU));
   assign w_gnt_ifu  = ifu_req_valid & ~w_gnt_lsu;
   assign w_accept   = (r_state == ST_IDLE) & (w_gnt_ifu | w_gnt_lsu);

   assign w_acc_addr = w_gnt_lsu ? lsu_req_addr : ifu_req_addr;
   assign w_acc_size = w_gnt_lsu ? lsu_req_size : SZ_W;
   assign w_misalign = is_misaligned(w_acc_addr[2:0], w_acc_size);

   assign w_bus_err  = (dn_r_resp == RESP_SLVERR) | (dn_r_resp == RESP_DECERR);

   assign dn_len     = 8'd0;

   ysyx_22041071_load_align u_align (
      .i_beat     (dn_r_data),
      .i_addr_lo  (r_addr[2:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_load     (w_load),
      .o_inst     (w_inst)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and all state-decoded outputs. Request fields are only
   // presented while the request is outstanding so idle outputs read 0.
   always_comb begin
      w_state_nxt    = r_state;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      ifu_resp_inst  = '0;
      ifu_resp_err   = 1'b0;
      lsu_resp_valid = 1'b0;
      lsu_resp_data  = '0;
      lsu_resp_err   = 1'b0;
      dn_ar_valid    = 1'b0;
      dn_id          = '0;
      dn_addr        = '0;
      dn_size        = '0;
      case (r_state)
         ST_IDLE: begin
            // Readies are masked during reset so nothing is accepted then.
            ifu_req_ready = reset_n & w_gnt_ifu;
            lsu_req_ready = reset_n & w_gnt_lsu;
            if (w_accept) begin
               w_state_nxt = w_misalign ? ST_RESP : ST_ADDR;
            end
         end
         ST_ADDR: begin
            dn_ar_valid = 1'b1;
            dn_id       = (r_owner == OWN_LSU) ? W_LSU_ID : W_IFU_ID;
            dn_addr     = r_addr;
            dn_size     = r_size;
            if (dn_ar_ready) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (dn_r_valid) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (r_owner == OWN_LSU) begin
               lsu_resp_valid = 1'b1;
               lsu_resp_data  = r_data;
               lsu_resp_err   = r_err;
            end else begin
               ifu_resp_valid = 1'b1;
               ifu_resp_inst  = r_data[31:0];
               ifu_resp_err   = r_err;
            end
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_last_grant <= OWN_IFU;
         r_owner      <= OWN_IFU;
         r_addr       <= '0;
         r_size       <= '0;
         r_unsigned   <= 1'b0;
         r_data       <= '0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_owner      <= w_gnt_lsu;
                  r_last_grant <= w_gnt_lsu;
                  r_addr       <= w_acc_addr;
                  r_size       <= w_acc_size;
                  r_unsigned   <= w_gnt_lsu & lsu_req_unsigned;
                  // A misaligned request goes straight to RESP with
                  // zero data and the error flag already set.
                  r_data       <= '0;
                  r_err        <= w_misalign;
               end
            end
            ST_DATA: begin
               if (dn_r_valid) begin
                  r_data <= (r_owner == OWN_LSU) ? w_load : {32'd0, w_inst};
                  r_err  <= w_bus_err;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
Name: ysyx_22041071_axi_rd_arb

Overview:
Read-request arbiter and response aligner that sits directly upstream of the AXI read-channel bridge. It takes single-beat read requests from the IFU (instruction fetch) and the LSU (loads), grants one at a time round-robin, and drives the bridge's CPU-side request interface. It captures the returned 64-bit beat, aligns and extends it per requester, and returns a one-cycle response pulse to the owner.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, bridge data width (fixed 64 in this block)
ID_W, 4, AXI ID width
IFU_ID, 0, ID issued for IFU reads
LSU_ID, 1, ID issued for LSU reads

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_addr  in  ADDR_W  fetch address
ifu_req_ready  out  1  IFU request accepted when valid&ready
ifu_resp_valid  out  1  one-cycle fetch response
ifu_resp_inst  out  32  instruction word
ifu_resp_err  out  1  bus or alignment error
lsu_req_valid  in  1  load request
lsu_req_addr  in  ADDR_W  load address
lsu_req_size  in  2  00=B, 01=H, 10=W, 11=D
lsu_req_unsigned  in  1  zero-extend when 1
lsu_req_ready  out  1  LSU request accepted
lsu_resp_valid  out  1  one-cycle load response
lsu_resp_data  out  64  aligned, extended load data
lsu_resp_err  out  1  bus or alignment error
dn_ar_valid  out  1  request to bridge
dn_ar_ready  in  1  bridge accepts request
dn_id  out  ID_W  request ID
dn_addr  out  ADDR_W  byte address (unaligned allowed)
dn_len  out  8  always 0 (single beat)
dn_size  out  2  transfer size
dn_r_valid  in  1  read beat valid
dn_r_data  in  64  masked beat data (bytes in place)
dn_r_resp  in  2  AXI resp

Behaviour:
- Reset: all outputs 0. State IDLE. last_grant = IFU, so the LSU wins the first tie.
- States: IDLE, ADDR, DATA, RESP.
- IDLE, grant logic (combinational):
  - Only one requester is granted.
  - If both are valid, the one not equal to last_grant wins.
  - Only the granted requester sees req_ready=1.
  - ifu_req_ready and lsu_req_ready are 0 in every state other than IDLE.
- On accept:
  - Latch owner, addr, size (IFU size fixed 2'b10), and unsigned flag.
  - Update last_grant.
  - If misaligned, go to RESP with err=1 and data 0, with no downstream transaction. IFU is misaligned when addr[1:0]!=0; LSU when addr is not a multiple of 2^size.
  - Otherwise go to ADDR.
- ADDR:
  - dn_ar_valid=1.
  - dn_id/addr/size/len are driven from the latched registers and are stable until the handshake.
  - On dn_ar_ready, go to DATA and drop dn_ar_valid in the next cycle.
- DATA:
  - Wait for dn_r_valid; it is ignored in all other states.
  - On dn_r_valid, register the aligned data and err = dn_r_resp[1], then go to RESP.
- RESP:
  - Exactly one cycle of owner resp_valid=1 with data and err; the other requester's outputs stay 0.
  - Go to IDLE. A new grant is possible in the following cycle.
- Minimum latency: accept in cycle N, ADDR at N+1, DATA at N+2, resp_valid at N+3 when ready and r_valid come immediately.
- Alignment:
  - sh = dn_r_data >> {addr[2:0],3'b000}.
  - Size B/H/W: take the low 8/16/32 bits, then sign-extend from the top bit, or zero-extend if unsigned.
  - Size D: use sh as is.
  - IFU: inst = addr[2] ? dn_r_data[63:32] : dn_r_data[31:0].
- Requesters hold valid and address until accepted. The arbiter does not buffer unaccepted requests.
- Reset mid-operation:
  - Return to IDLE with all outputs 0 and the in-flight transaction abandoned.
  - The bridge shares the same reset.

Decomposition:
- Package ysyx_22041071_rd_arb_pkg holds:
  - state encodings;
  - size codes;
  - AXI resp codes (OKAY, EXOKAY, SLVERR, DECERR);
  - IFU_ID/LSU_ID defaults.
- One combinational sub-module, ysyx_22041071_load_align, holds the shift and extension logic.

Test Plan:
- IFU addr 0x8000_0004; bridge returns 0x1122334455667788, resp 0 → dn_addr 0x80000004, size 2, len 0, id 0; ifu_resp_inst 0x11223344, err 0, resp_valid at N+3.
- LSU LB signed at addr 0x8000_0003; beat byte3=0x85 → lsu_resp_data 0xFFFFFFFFFFFFFF85. Same load with unsigned=1 → 0x0000000000000085.
- IFU and LSU both valid after reset → LSU granted first. On return to IDLE with both still valid → IFU granted. ifu_resp_valid and lsu_resp_valid are never high in the same cycle.
- LSU LW at addr 0x8000_0002 → no dn_ar_valid; lsu_resp_valid at N+1 with err=1 and data 0.
- dn_ar_ready held 0 for 5 cycles → dn_ar_valid and all fields stable. dn_r_resp=2'b11 → err=1.
- reset_n low during DATA → next cycle IDLE with all outputs 0. A later dn_r_valid produces no resp_valid.
